// File: rtl/exe_mem_pkg.sv
// Shared widths, MEM control bit positions and payload sizing for the EXE->MEM stage.
package exe_mem_pkg;
   localparam int DATA_W_DEF      = 32;
   localparam int WIDE_W_DEF      = 64;
   localparam int REG_AW_DEF      = 5;
   localparam int WB_CTL_W_DEF    = 10;
   localparam int MEM_CTL_W_DEF   = 3;
   localparam int STALL_CNT_W_DEF = 16;

   localparam int MEMCTL_READ    = 2;
   localparam int MEMCTL_WRITE   = 1;
   localparam int MEMCTL_WRITE64 = 0;

   // Payload = {alu64, alu32, rt64, rt32, regwr, rs, wb_ctl, mem_ctl}
   function automatic int payload_w(input int dw, input int ww, input int raw,
                                    input int wbw, input int mcw);
      return 2*ww + 3*dw + raw + wbw + mcw;
   endfunction
endpackage

// File: rtl/exe_mem_pipe_slot.sv
// One pipeline holding slot: valid bit plus payload register. Clear beats load.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic         vld,
   output logic [W-1:0] q
);
   logic         vld_d, vld_q;
   logic [W-1:0] data_d, data_q;

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (clr) begin
         vld_d = 1'b0;
      end else if (ld) begin
         vld_d  = 1'b1;
         data_d = d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign vld = vld_q;
   assign q   = data_q;
endmodule

// File: rtl/exe_mem_pipe.sv
// EXE->MEM pipeline register with valid/ready handshake, optional skid slot,
// flush and a saturating MEM stall counter.
module exe_mem_pipe
   import exe_mem_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WIDE_W      = WIDE_W_DEF,
   parameter int REG_AW      = REG_AW_DEF,
   parameter int WB_CTL_W    = WB_CTL_W_DEF,
   parameter int MEM_CTL_W   = MEM_CTL_W_DEF,
   parameter int SKID        = 1,
   parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDE_W-1:0]      OUT_ALU64,
   input  logic [DATA_W-1:0]      OUT_ALU32,
   input  logic [WIDE_W-1:0]      Rt_data64_EXE,
   input  logic [DATA_W-1:0]      Rt_data_EXE,
   input  logic [REG_AW-1:0]      RegWr_EXE,
   input  logic [DATA_W-1:0]      Rs_data_EXE,
   input  logic [WB_CTL_W-1:0]    WB_control_EX,
   input  logic [MEM_CTL_W-1:0]   MEM_control_EX,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDE_W-1:0]      OUT_ALU64_MEM,
   output logic [DATA_W-1:0]      Adrs_MEM,
   output logic [WIDE_W-1:0]      Rt_data64_MEM,
   output logic [DATA_W-1:0]      Rt_data_MEM,
   output logic [REG_AW-1:0]      RegWr_MEM,
   output logic [DATA_W-1:0]      HILO_write_MEM,
   output logic [WB_CTL_W-1:0]    WB_control_MEM,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   MemWrite64,
   output logic [STALL_CNT_W-1:0] stall_cnt
);
   localparam int PW = payload_w(DATA_W, WIDE_W, REG_AW, WB_CTL_W, MEM_CTL_W);

   logic [PW-1:0]          pay_in, main_din, main_q, skid_q;
   logic                   main_v, skid_v;
   logic                   main_ld, main_clr, skid_ld, skid_clr;
   logic                   accept, retire;
   logic                   in_ready_d, in_ready_q;
   logic [STALL_CNT_W-1:0] stall_d, stall_q;
   logic [WB_CTL_W-1:0]    wb_raw;
   logic [MEM_CTL_W-1:0]   mc_raw;

   assign pay_in = {OUT_ALU64, OUT_ALU32, Rt_data64_EXE, Rt_data_EXE,
                    RegWr_EXE, Rs_data_EXE, WB_control_EX, MEM_control_EX};

   assign in_ready = (SKID != 0) ? in_ready_q : (~main_v | out_ready);
   assign retire   = main_v & out_ready;
   // A flushed cycle never captures, even when in_ready is high.
   assign accept   = in_valid & in_ready & ~Flush;

   always_comb begin
      main_din   = pay_in;
      main_ld    = accept;
      skid_ld    = 1'b0;
      skid_clr   = 1'b0;
      in_ready_d = 1'b1;
      if (SKID != 0) begin
         // in_ready is low whenever skid holds, so skid->main never races an accept.
         main_din   = skid_v ? skid_q : pay_in;
         main_ld    = (skid_v & retire) | (accept & (~main_v | retire));
         skid_ld    = accept & main_v & ~retire;
         skid_clr   = Flush | retire;
         in_ready_d = Flush | ~(skid_ld | (skid_v & ~retire));
      end
      main_clr = Flush | (retire & ~main_ld);
   end

   always_comb begin
      stall_d = stall_q;
      if (main_v & ~out_ready & ~(&stall_q))
         stall_d = stall_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         in_ready_q <= 1'b1;
         stall_q    <= '0;
      end else begin
         in_ready_q <= in_ready_d;
         stall_q    <= stall_d;
      end
   end

   pipe_slot #(.W(PW)) u_main (
      .clk (Clk),
      .rst (Rst),
      .clr (main_clr),
      .ld  (main_ld),
      .d   (main_din),
      .vld (main_v),
      .q   (main_q)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_slot #(.W(PW)) u_skid (
            .clk (Clk),
            .rst (Rst),
            .clr (skid_clr),
            .ld  (skid_ld),
            .d   (pay_in),
            .vld (skid_v),
            .q   (skid_q)
         );
      end else begin : g_noskid
         assign skid_v = 1'b0;
         assign skid_q = '0;
      end
   endgenerate

   assign {OUT_ALU64_MEM, Adrs_MEM, Rt_data64_MEM, Rt_data_MEM,
           RegWr_MEM, HILO_write_MEM, wb_raw, mc_raw} = main_q;

   // Control is gated by valid so an empty stage can never issue a store.
   assign out_valid      = main_v;
   assign WB_control_MEM = main_v ? wb_raw : '0;
   assign MemRead        = main_v & mc_raw[MEMCTL_READ];
   assign MemWrite       = main_v & mc_raw[MEMCTL_WRITE];
   assign MemWrite64     = main_v & mc_raw[MEMCTL_WRITE64];
   assign stall_cnt      = stall_q;
endmodule

// File: tb/tb_exe_mem_pipe.sv
// Drives a SKID=1 and a SKID=0 (4-bit stall counter) instance with identical stimulus
// and checks both against queue-based reference models plus a directed vector table.
module tb_exe_mem_pipe;
   typedef struct packed {
      logic [63:0] a64;
      logic [31:0] a32;
      logic [63:0] r64;
      logic [31:0] r32;
      logic [4:0]  rw;
      logic [31:0] rs;
      logic [9:0]  wb;
      logic [2:0]  mc;
   } pl_t;

   typedef struct packed {
      logic        ov;
      logic        ir;
      logic [63:0] a64;
      logic [31:0] a32;
      logic [63:0] r64;
      logic [31:0] r32;
      logic [4:0]  rw;
      logic [31:0] rs;
      logic [9:0]  wb;
      logic        rd;
      logic        wr;
      logic        w64;
      logic [15:0] st;
   } obs_t;

   typedef struct {
      bit          iv;
      bit          ord;
      bit          fl;
      logic [31:0] a32;
      logic [2:0]  mc;
      bit          e_ov;
      bit          e_ir;
      logic [31:0] e_adrs;
      int          e_st;
   } vec_t;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic Rst, Flush, in_valid, out_ready;
   pl_t  cur;

   logic        ir1, ov1, rd1, wr1, w641, ir0, ov0, rd0, wr0, w640;
   logic [63:0] a641, r641, a640, r640;
   logic [31:0] a321, r321, rs1, a320, r320, rs0;
   logic [4:0]  rw1, rw0;
   logic [9:0]  wb1, wb0;
   logic [15:0] st1;
   logic [3:0]  st0;
   obs_t        o1, o0;

   exe_mem_pipe #(.SKID(1), .STALL_CNT_W(16)) dut1 (
      .Clk(Clk), .Rst(Rst), .Flush(Flush), .in_valid(in_valid), .in_ready(ir1),
      .OUT_ALU64(cur.a64), .OUT_ALU32(cur.a32), .Rt_data64_EXE(cur.r64), .Rt_data_EXE(cur.r32),
      .RegWr_EXE(cur.rw), .Rs_data_EXE(cur.rs), .WB_control_EX(cur.wb), .MEM_control_EX(cur.mc),
      .out_valid(ov1), .out_ready(out_ready), .OUT_ALU64_MEM(a641), .Adrs_MEM(a321),
      .Rt_data64_MEM(r641), .Rt_data_MEM(r321), .RegWr_MEM(rw1), .HILO_write_MEM(rs1),
      .WB_control_MEM(wb1), .MemRead(rd1), .MemWrite(wr1), .MemWrite64(w641), .stall_cnt(st1)
   );

   exe_mem_pipe #(.SKID(0), .STALL_CNT_W(4)) dut0 (
      .Clk(Clk), .Rst(Rst), .Flush(Flush), .in_valid(in_valid), .in_ready(ir0),
      .OUT_ALU64(cur.a64), .OUT_ALU32(cur.a32), .Rt_data64_EXE(cur.r64), .Rt_data_EXE(cur.r32),
      .RegWr_EXE(cur.rw), .Rs_data_EXE(cur.rs), .WB_control_EX(cur.wb), .MEM_control_EX(cur.mc),
      .out_valid(ov0), .out_ready(out_ready), .OUT_ALU64_MEM(a640), .Adrs_MEM(a320),
      .Rt_data64_MEM(r640), .Rt_data_MEM(r320), .RegWr_MEM(rw0), .HILO_write_MEM(rs0),
      .WB_control_MEM(wb0), .MemRead(rd0), .MemWrite(wr0), .MemWrite64(w640), .stall_cnt(st0)
   );

   assign o1 = '{ov:ov1, ir:ir1, a64:a641, a32:a321, r64:r641, r32:r321, rw:rw1, rs:rs1,
                 wb:wb1, rd:rd1, wr:wr1, w64:w641, st:st1};
   assign o0 = '{ov:ov0, ir:ir0, a64:a640, a32:a320, r64:r640, r32:r320, rw:rw0, rs:rs0,
                 wb:wb0, rd:rd0, wr:wr0, w64:w640, st:{12'd0, st0}};

   int checks = 0;
   int errors = 0;

   // Reference state: an ordered list of held entries per instance.
   pl_t q1[$];
   pl_t q0[$];
   int  cnt1 = 0;
   int  cnt0 = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic pl_t rand_pl(input logic [31:0] a32, input logic [2:0] mc);
      pl_t p;
      p.a64 = {$urandom, $urandom};
      p.a32 = a32;
      p.r64 = {$urandom, $urandom};
      p.r32 = $urandom;
      p.rw  = 5'($urandom);
      p.rs  = $urandom;
      p.wb  = 10'($urandom);
      p.mc  = mc;
      return p;
   endfunction

   task automatic check_one(input string tag, input obs_t o, input int sz, input pl_t f,
                            input int cnt, input bit ir_exp);
      chk({tag, ".out_valid"}, 64'(o.ov), 64'(sz > 0));
      chk({tag, ".in_ready"}, 64'(o.ir), 64'(ir_exp));
      chk({tag, ".stall_cnt"}, 64'(o.st), 64'(cnt));
      if (sz > 0) begin
         chk({tag, ".alu64"}, o.a64, f.a64);
         chk({tag, ".adrs"}, 64'(o.a32), 64'(f.a32));
         chk({tag, ".rt64"}, o.r64, f.r64);
         chk({tag, ".rt32"}, 64'(o.r32), 64'(f.r32));
         chk({tag, ".regwr"}, 64'(o.rw), 64'(f.rw));
         chk({tag, ".hilo"}, 64'(o.rs), 64'(f.rs));
         chk({tag, ".wb"}, 64'(o.wb), 64'(f.wb));
         chk({tag, ".memctl"}, 64'({o.rd, o.wr, o.w64}), 64'(f.mc));
      end else begin
         chk({tag, ".wb_idle"}, 64'(o.wb), 64'd0);
         chk({tag, ".memctl_idle"}, 64'({o.rd, o.wr, o.w64}), 64'd0);
      end
   endtask

   function automatic bit ir1_m();
      return q1.size() < 2;
   endfunction

   function automatic bit ir0_m();
      return (q0.size() == 0) || out_ready;
   endfunction

   task automatic drive(input bit iv, input bit ord, input bit fl, input pl_t p);
      @(negedge Clk);
      in_valid  = iv;
      out_ready = ord;
      Flush     = fl;
      cur       = p;
      #1;
   endtask

   task automatic model_check();
      pl_t f1, f0;
      f1 = (q1.size() > 0) ? q1[0] : '0;
      f0 = (q0.size() > 0) ? q0[0] : '0;
      check_one("skid1", o1, q1.size(), f1, cnt1, ir1_m());
      check_one("skid0", o0, q0.size(), f0, cnt0, ir0_m());
   endtask

   // Advance both models across the coming clock edge.
   task automatic model_update();
      bit a1, a0;
      a1 = in_valid && ir1_m() && !Flush;
      a0 = in_valid && ir0_m() && !Flush;
      if (q1.size() > 0 && !out_ready && cnt1 < 65535) cnt1++;
      if (q0.size() > 0 && !out_ready && cnt0 < 15) cnt0++;
      if (q1.size() > 0 && out_ready) void'(q1.pop_front());
      if (q0.size() > 0 && out_ready) void'(q0.pop_front());
      if (a1) q1.push_back(cur);
      if (a0) q0.push_back(cur);
      if (Flush) begin
         q1.delete();
         q0.delete();
      end
   endtask

   task automatic cycle(input bit iv, input bit ord, input bit fl, input pl_t p);
      drive(iv, ord, fl, p);
      model_check();
      model_update();
   endtask

   function automatic vec_t mk(input bit iv, input bit ord, input bit fl, input logic [31:0] a32,
                               input logic [2:0] mc, input bit e_ov, input bit e_ir,
                               input logic [31:0] e_adrs, input int e_st);
      vec_t v;
      v = '{iv:iv, ord:ord, fl:fl, a32:a32, mc:mc, e_ov:e_ov, e_ir:e_ir, e_adrs:e_adrs, e_st:e_st};
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      // Directed table, expectations for the SKID=1 instance sampled before each edge.
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1, 1, 0, 32'h100 + i, 3'b100, i > 0, 1, 32'h100 + i - 1, 0));
      tbl.push_back(mk(0, 1, 0, 32'h0,   3'b000, 1, 1, 32'h107, 0));
      tbl.push_back(mk(1, 0, 0, 32'h200, 3'b001, 0, 1, 32'h0,   0));
      tbl.push_back(mk(1, 0, 0, 32'h201, 3'b001, 1, 1, 32'h200, 0));
      tbl.push_back(mk(1, 0, 0, 32'h202, 3'b001, 1, 0, 32'h200, 1));
      tbl.push_back(mk(1, 0, 0, 32'h202, 3'b001, 1, 0, 32'h200, 2));
      tbl.push_back(mk(0, 1, 0, 32'h0,   3'b000, 1, 0, 32'h200, 3));
      tbl.push_back(mk(0, 1, 0, 32'h0,   3'b000, 1, 1, 32'h201, 3));
      tbl.push_back(mk(0, 1, 0, 32'h0,   3'b000, 0, 1, 32'h0,   3));
      tbl.push_back(mk(1, 0, 0, 32'h300, 3'b010, 0, 1, 32'h0,   3));
      tbl.push_back(mk(1, 0, 0, 32'h301, 3'b010, 1, 1, 32'h300, 3));
      tbl.push_back(mk(1, 0, 1, 32'h302, 3'b010, 1, 0, 32'h300, 4));
      tbl.push_back(mk(0, 1, 0, 32'h0,   3'b000, 0, 1, 32'h0,   5));

      Rst = 1'b1; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cur = '0;
      @(negedge Clk);
      #1;
      chk("rst.out_valid1", 64'(ov1), 64'd0);
      chk("rst.in_ready1", 64'(ir1), 64'd1);
      chk("rst.adrs1", 64'(a321), 64'd0);
      chk("rst.alu64_1", a641, 64'd0);
      chk("rst.ctl1", 64'({wb1, rd1, wr1, w641}), 64'd0);
      chk("rst.stall1", 64'(st1), 64'd0);
      chk("rst.out_valid0", 64'(ov0), 64'd0);
      chk("rst.ctl0", 64'({wb0, rd0, wr0, w640}), 64'd0);
      Rst = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].iv, tbl[i].ord, tbl[i].fl, rand_pl(tbl[i].a32, tbl[i].mc));
         chk($sformatf("tbl%0d.out_valid", i), 64'(ov1), 64'(tbl[i].e_ov));
         chk($sformatf("tbl%0d.in_ready", i), 64'(ir1), 64'(tbl[i].e_ir));
         chk($sformatf("tbl%0d.stall", i), 64'(st1), 64'(tbl[i].e_st));
         if (tbl[i].e_ov) chk($sformatf("tbl%0d.adrs", i), 64'(a321), 64'(tbl[i].e_adrs));
         else chk($sformatf("tbl%0d.memwrite_idle", i), 64'(wr1), 64'd0);
         model_check();
         model_update();
      end

      // SKID=0: out_ready toggling, in_ready must track it combinationally.
      for (int i = 0; i < 12; i++)
         cycle(1, i[0] == 1'b0, 0, rand_pl(32'h400 + i, 3'($urandom)));

      // 20 cycles of back-pressure saturates the 4-bit counter.
      for (int i = 0; i < 20; i++)
         cycle(1, 0, 0, rand_pl(32'h500 + i, 3'($urandom)));
      drive(0, 0, 0, '0);
      chk("sat.stall0", 64'(st0), 64'hF);
      model_check();
      model_update();

      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0,
               rand_pl($urandom, 3'($urandom)));
      for (int i = 0; i < 4; i++)
         cycle(0, 1, 0, '0);

      // Reset while holding stores: outputs must drop in the same cycle.
      cycle(1, 0, 0, rand_pl(32'h600, 3'b010));
      cycle(1, 0, 0, rand_pl(32'h601, 3'b010));
      @(negedge Clk);
      in_valid = 1'b1;
      Rst = 1'b1;
      #1;
      chk("midrst.out_valid1", 64'(ov1), 64'd0);
      chk("midrst.memwrite1", 64'(wr1), 64'd0);
      chk("midrst.in_ready1", 64'(ir1), 64'd1);
      chk("midrst.stall1", 64'(st1), 64'd0);
      chk("midrst.out_valid0", 64'(ov0), 64'd0);
      chk("midrst.memwrite0", 64'(wr0), 64'd0);
      chk("midrst.stall0", 64'(st0), 64'd0);
      q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0;
      @(negedge Clk);
      Rst = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++)
         cycle(1, 1, 0, rand_pl(32'h700 + i, 3'($urandom)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
